// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: converts decoded field tuples into 32-bit words at
// sequential word addresses, one program burst per start pulse, with a one-deep output register.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [7:0]  prog_len,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_type,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic        busy,
    output logic        done,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [3:0] TypeR      = 4'd0;
    localparam logic [3:0] TypeIAlu   = 4'd1;
    localparam logic [3:0] TypeLoad   = 4'd2;
    localparam logic [3:0] TypeJalr   = 4'd3;
    localparam logic [3:0] TypeStore  = 4'd4;
    localparam logic [3:0] TypeBranch = 4'd5;
    localparam logic [3:0] TypeLui    = 4'd6;
    localparam logic [3:0] TypeAuipc  = 4'd7;
    localparam logic [3:0] TypeJal    = 4'd8;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [31:0] Nop = 32'h0000_0013;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  remaining_q, remaining_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_addr_q, out_addr_d;
    logic        out_err_q, out_err_d;

    logic        load;
    logic        accept;
    logic [31:0] enc_instr;
    logic        enc_err;
    logic        legal;
    logic        fits12, fits13, fits21;
    logic        unused_base;

    assign unused_base = ^base_addr[1:0];

    // Immediate range checks as sign-extension tests on the upper bits.
    assign fits12 = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign fits13 = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
    assign fits21 = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);

    always_comb begin
        enc_instr = Nop;
        enc_err   = 1'b0;
        legal     = 1'b1;
        case (in_type)
            TypeR: begin
                enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OpR};
            end
            TypeIAlu: begin
                legal     = fits12;
                enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OpIAlu};
            end
            TypeLoad: begin
                legal     = fits12;
                enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OpLoad};
            end
            TypeJalr: begin
                legal     = fits12;
                enc_instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, OpJalr};
            end
            TypeStore: begin
                legal     = fits12;
                enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OpStore};
            end
            TypeBranch: begin
                legal     = fits13 && !in_imm[0];
                enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], OpBranch};
            end
            TypeLui: begin
                legal     = (in_imm[31:20] == '0);
                enc_instr = {in_imm[19:0], in_rd, OpLui};
            end
            TypeAuipc: begin
                legal     = (in_imm[31:20] == '0);
                enc_instr = {in_imm[19:0], in_rd, OpAuipc};
            end
            TypeJal: begin
                legal     = fits21 && !in_imm[0];
                enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OpJal};
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        if (!legal) begin
            enc_instr = Nop;
            enc_err   = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (remaining_q == '0) state_d = StDrain;
            StDrain: if (!out_valid_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        in_ready = (state_q == StRun) && (remaining_q != '0) && (!out_valid_q || out_ready);
    end

    assign load   = (state_q == StIdle) && start;
    assign accept = in_valid && in_ready;

    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        err_count_d = err_count_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        if (load) begin
            addr_d      = {base_addr[31:2], 2'b00};
            remaining_d = prog_len;
            err_count_d = '0;
        end else if (accept) begin
            addr_d      = addr_q + 32'd4;
            remaining_d = remaining_q - 8'd1;
            if (enc_err && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
        // A fresh accept wins over a drain in the same cycle, keeping one word per cycle.
        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_instr;
            out_addr_d  = addr_q;
            out_err_d   = enc_err;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            err_count_q <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            err_count_q <= err_count_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings plus randomized bursts scored
// against an arithmetic model of the RV32I field layout and range rules.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start, in_valid, in_ready, out_valid, out_ready, out_err, busy, done;
    logic [31:0] base_addr, in_imm, out_instr, out_addr;
    logic [7:0]  prog_len, err_count;
    logic [3:0]  in_type;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;

    int checks = 0;
    int errors = 0;

    instr_encoder dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .prog_len(prog_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .busy(busy), .done(done), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference encoding from the ISA rules, returning {err, word}.
    function automatic logic [32:0] model_enc(input logic [3:0] t, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [31:0] imm);
        longint s, u, w, lrd, lrs1, lrs2, lf3, lf7;
        bit ok;
        s = longint'($signed(imm));
        u = longint'(imm);
        lrd = longint'(rd) << 7;
        lrs1 = longint'(rs1) << 15;
        lrs2 = longint'(rs2) << 20;
        lf3 = longint'(f3) << 12;
        lf7 = longint'(f7) << 25;
        ok = 1'b1;
        w = 64'h0;
        case (t)
            4'd0: w = lf7 + lrs2 + lrs1 + lf3 + lrd + 64'h33;
            4'd1, 4'd2, 4'd3: begin
                ok = (s >= -2048) && (s <= 2047);
                w = ((u % 4096) << 20) + lrs1 + ((t == 4'd3) ? 64'h0 : lf3) + lrd +
                    ((t == 4'd1) ? 64'h13 : (t == 4'd2) ? 64'h03 : 64'h67);
            end
            4'd4: begin
                ok = (s >= -2048) && (s <= 2047);
                w = (((u / 32) % 128) << 25) + lrs2 + lrs1 + lf3 + ((u % 32) << 7) + 64'h23;
            end
            4'd5: begin
                ok = (s >= -4096) && (s <= 4094) && (u % 2 == 0);
                w = (((u / 4096) % 2) << 31) + (((u / 32) % 64) << 25) + lrs2 + lrs1 + lf3 +
                    (((u / 2) % 16) << 8) + (((u / 2048) % 2) << 7) + 64'h63;
            end
            4'd6, 4'd7: begin
                ok = (u < 1048576);
                w = ((u % 1048576) << 12) + lrd + ((t == 4'd6) ? 64'h37 : 64'h17);
            end
            4'd8: begin
                ok = (s >= -1048576) && (s <= 1048574) && (u % 2 == 0);
                w = (((u / 1048576) % 2) << 31) + (((u / 2) % 1024) << 21) +
                    (((u / 2048) % 2) << 20) + (((u / 4096) % 256) << 12) + lrd + 64'h6F;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) w = 64'h13;
        return {~ok, w[31:0]};
    endfunction

    // Scoreboard monitor: all model state lives here.
    logic [64:0] exp_q[$];
    logic [64:0] sb_e;
    logic [32:0] sb_r;
    logic [31:0] m_addr = 32'h0;
    int          m_errs = 0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (start && !busy) begin
                m_addr = {base_addr[31:2], 2'b00};
                m_errs = 0;
            end
            if (out_valid && out_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_word", 32'(out_valid), 32'h0);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_instr", out_instr, sb_e[31:0]);
                    check("sb_addr", out_addr, sb_e[63:32]);
                    check("sb_err", 32'(out_err), 32'(sb_e[64]));
                end
            end
            if (in_valid && in_ready) begin
                sb_r = model_enc(in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
                exp_q.push_back({sb_r[32], m_addr, sb_r[31:0]});
                m_addr = m_addr + 32'd4;
                if (sb_r[32] && m_errs < 255) m_errs++;
                acc_cnt++;
            end
            if (done) done_cnt++;
        end
    end

    int bnd[16] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096,
                    -4097, -4098, 1048574, 1048575, -1048576, -1048578, 1048576, 3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [7:0] n);
        tick();
        start = 1'b1;
        base_addr = b;
        prog_len = n;
        tick();
        start = 1'b0;
    endtask

    task automatic set_fields(input logic [3:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
        in_type = t;
        in_rd = rd;
        in_rs1 = rs1;
        in_rs2 = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm = imm;
    endtask

    task automatic send(input logic [3:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        int last = acc_cnt;
        int n = 0;
        set_fields(t, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        while (acc_cnt == last && n < 100) begin
            tick();
            n++;
        end
        if (acc_cnt == last) check("send_timeout", 32'(n), 32'd0);
        in_valid = 1'b0;
    endtask

    // Encode one word with the output stalled, check it against a known value, then drain it.
    task automatic send_chk(input string tag, input logic [3:0] t, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm,
                            input logic [31:0] ei, input logic [31:0] ea, input logic ee);
        out_ready = 1'b0;
        send(t, rd, rs1, rs2, f3, f7, imm);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_instr"}, out_instr, ei);
        check({tag, "_addr"}, out_addr, ea);
        check({tag, "_err"}, 32'(out_err), 32'(ee));
        tick();
        out_ready = 1'b1;
        tick();
    endtask

    task automatic wait_done(input string tag);
        int last = done_cnt;
        int n = 0;
        while (done_cnt == last && n < 600) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt - last), 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'(m_errs));
    endtask

    task automatic rand_fields();
        int k;
        if ($urandom_range(0, 9) == 0) in_type = 4'($urandom_range(9, 15));
        else in_type = 4'($urandom_range(0, 8));
        in_rd = 5'($urandom);
        in_rs1 = 5'($urandom);
        in_rs2 = 5'($urandom);
        in_funct3 = 3'($urandom);
        in_funct7 = 7'($urandom);
        case ($urandom_range(0, 3))
            0: in_imm = $urandom;
            1: in_imm = 32'(int'($urandom_range(0, 8191)) - 4096);
            2: begin
                k = int'($urandom_range(0, 15));
                in_imm = 32'(bnd[k]);
            end
            default: in_imm = $urandom & 32'h000F_FFFF;
        endcase
    endtask

    task automatic rand_burst(input int n);
        int issued = 0;
        int guard = 0;
        int last;
        int d0 = done_cnt;
        int p0 = pop_cnt;
        do_start($urandom, 8'(n));
        last = acc_cnt;
        while (done_cnt == d0 && guard < 3000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || acc_cnt != last) begin
                last = acc_cnt;
                if (issued < n && $urandom_range(0, 3) != 0) begin
                    rand_fields();
                    in_valid = 1'b1;
                    issued++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            tick();
            guard++;
        end
        check("rand_done_seen", 32'(done_cnt != d0), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rand_busy_low", 32'(busy), 32'd0);
        check("rand_word_count", 32'(pop_cnt - p0), 32'(n));
        check("rand_sb_drained", 32'(exp_q.size()), 32'd0);
        check("rand_err_count", 32'(err_count), 32'(m_errs));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        start = 1'b0; base_addr = '0; prog_len = '0; in_valid = 1'b0; out_ready = 1'b0;
        set_fields(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_addr", out_addr, 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        repeat (2) tick();
        rst = 1'b0;

        // Basic program with unused fields deliberately non-zero.
        do_start(32'h100, 8'd3);
        send_chk("addi", 4'd1, 5'd1, 5'd0, 5'd9, 3'd0, 7'h7F, 32'd5, 32'h00500093, 32'h100, 1'b0);
        send_chk("add", 4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd77, 32'h002081B3, 32'h104, 1'b0);
        send_chk("sw", 4'd4, 5'd17, 5'd1, 5'd2, 3'd2, 7'h55, 32'd8, 32'h0020A423, 32'h108, 1'b0);
        wait_done("basic");

        // Branch/jump/upper encodings and illegal substitutions.
        do_start(32'h1003, 8'd6);
        send_chk("beq", 4'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE208EE3, 32'h1000,
                 1'b0);
        send_chk("jal", 4'd8, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0000006F, 32'h1004, 1'b0);
        send_chk("lui", 4'd6, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345, 32'h123452B7, 32'h1008,
                 1'b0);
        send_chk("ill_imm", 4'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h13, 32'h100C, 1'b1);
        send_chk("ill_br", 4'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h13, 32'h1010, 1'b1);
        send_chk("ill_type", 4'd12, 5'd1, 5'd2, 5'd3, 3'd1, 7'd0, 32'd0, 32'h13, 32'h1014, 1'b1);
        wait_done("legal_illegal");
        check("err_count_three", 32'(err_count), 32'd3);

        // Backpressure: one word held while a second waits on in_valid.
        out_ready = 1'b0;
        do_start(32'h200, 8'd3);
        p0 = pop_cnt;
        send(4'd1, 5'd4, 5'd5, 5'd0, 3'd0, 7'd0, 32'h7FF);
        set_fields(4'd0, 5'd6, 5'd7, 5'd8, 3'd0, 7'h20, 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold_instr", out_instr, 32'h7FF28213);
            check("bp_hold_addr", out_addr, 32'h200);
            tick();
        end
        out_ready = 1'b1;
        send(4'd0, 5'd6, 5'd7, 5'd8, 3'd0, 7'h20, 32'd0);
        send(4'd3, 5'd1, 5'd2, 5'd0, 3'd7, 7'd0, 32'hFFFF_F800);
        wait_done("backpressure");
        check("bp_word_count", 32'(pop_cnt - p0), 32'd3);

        // Empty burst: done is seen in the third cycle after the start edge.
        tick();
        start = 1'b1; base_addr = 32'h500; prog_len = 8'd0;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("len0_out_valid", 32'(out_valid), 32'd0);
            check("len0_done", 32'(done), 32'(i == 3));
            check("len0_busy", 32'(busy), 32'(i <= 3));
        end

        // Address wrap at the top of the space.
        do_start(32'hFFFF_FFFC, 8'd2);
        send_chk("wrap0", 4'd7, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF, 32'hFFFFF497,
                 32'hFFFF_FFFC, 1'b0);
        send_chk("wrap1", 4'd2, 5'd9, 5'd3, 5'd0, 3'd2, 7'd0, 32'hFFFF_F800, 32'h8001A483,
                 32'h0000_0000, 1'b0);
        wait_done("wrap");

        // Full-throughput burst of illegal words: one accept per cycle, counter reaches 255.
        out_ready = 1'b1;
        do_start(32'h0, 8'd255);
        p0 = acc_cnt;
        set_fields(4'd15, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1;
        n = 0;
        while (acc_cnt - p0 < 255 && n < 400) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("thru_cycles", 32'(n), 32'd255);
        wait_done("thru");
        check("err_count_255", 32'(err_count), 32'd255);

        for (int b = 0; b < 4; b++) rand_burst(int'($urandom_range(1, 40)));

        // Asynchronous reset with a word held, then a clean restart.
        out_ready = 1'b0;
        do_start(32'h300, 8'd2);
        send(4'd1, 5'd2, 5'd3, 5'd0, 3'd4, 7'd0, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_out_instr", out_instr, 32'd0);
        check("arst_out_addr", out_addr, 32'd0);
        check("arst_err_count", 32'(err_count), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("arst_idle_wait", 32'(busy), 32'd0);
        end
        do_start(32'h400, 8'd1);
        send_chk("arst_new", 4'd6, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE, 32'hABCDE3B7,
                 32'h400, 1'b0);
        wait_done("arst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 start  in  1  one-cycle pulse; begins a program burst when in IDLE; ignored otherwise.
REQ-004 base_addr  in  32  byte address of the first word; bits[1:0] are forced to 0 when loaded.
REQ-005 prog_len  in  8  number of instructions in the burst, sampled on start; 0 is legal.
REQ-006 in_valid / in_ready  in / out  1 / 1  field-input handshake; a transfer occurs on a cycle where both are 1.
REQ-007 in_type  in  4  0 R, 1 I-ALU, 2 LOAD, 3 JALR, 4 STORE, 5 BRANCH, 6 LUI, 7 AUIPC, 8 JAL; 9-15 are illegal.
REQ-008 in_rd, in_rs1, in_rs2  in  5 each  register fields.
REQ-009 in_funct3 / in_funct7  in  3 / 7  function fields; funct7 is used by R only.
REQ-010 in_imm  in  32  two's-complement immediate; byte offset for BRANCH/JAL; 20-bit upper value for LUI/AUIPC.
REQ-011 out_valid / out_ready  out / in  1 / 1  encoded-word handshake.
REQ-012 out_instr  out  32  encoded RV32I word.
REQ-013 out_addr  out  32  byte address of out_instr.
REQ-014 out_err  out  1  qualifies out_instr: 1 means the input was illegal and out_instr is a substituted NOP.
REQ-015 busy / done  out  1 / 1  busy is high outside IDLE; done is a one-cycle pulse at burst end.
REQ-016 err_count  out  8  number of illegal inputs since the last start; saturates at 255.

Function
REQ-017 State machine: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start go to RUN; load addr=base_addr, remaining=prog_len, err_count=0.
  - RUN: when remaining reaches 0, go to DRAIN.
  - DRAIN: when out_valid=0, go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
REQ-018 If start arrives with prog_len=0: RUN lasts 0 accepts; done asserts exactly 3 cycles after the start edge, and out_valid never rises.
REQ-019 in_ready = (state==RUN) && (remaining!=0) && (!out_valid || out_ready).
REQ-020 On each accept:
  - register out_instr, out_addr=addr and out_err; out_valid=1 on the next cycle (1-cycle latency);
  - addr += 4 with modulo-2^32 wrap;
  - remaining decrements.
REQ-021 While out_valid=1 && out_ready=0, out_instr, out_addr and out_err hold stable.
REQ-022 Simultaneous drain and accept in the same cycle loads the new word, so out_valid stays 1 (full throughput, one word per cycle).
REQ-023 Opcode per type: R 0110011, I-ALU 0010011, LOAD 0000011, JALR 1100111, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111.
REQ-024 Field placement:
  - rd goes to [11:7] for R, I-ALU, LOAD, JALR, LUI, AUIPC, JAL;
  - funct3 goes to [14:12] and rs1 to [19:15] for R, I, S, B;
  - rs2 goes to [24:20] for R, S, B;
  - funct7 goes to [31:25] for R only;
  - JALR uses funct3=000 regardless of in_funct3.
REQ-025 Immediate scatter:
  - I: imm[11:0]→[31:20].
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7].
  - B: imm[12]→[31], imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→[7].
  - J: imm[20]→[31], imm[10:1]→[30:21], imm[11]→[20], imm[19:12]→[19:12].
  - U: imm[19:0]→[31:12].
REQ-026 Range rules (violation = illegal):
  - I/LOAD/JALR/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094] and imm[0]=0.
  - J: imm in [-2^20, 2^20-2] and imm[0]=0.
  - U: imm[31:20]=0.
REQ-027 An illegal type or range violation causes:
  - out_instr=0x00000013, out_err=1;
  - err_count increments, saturating at 255;
  - the address still advances.

Reset
REQ-028 rst asserted forces, immediately and regardless of clk:
  - state=IDLE;
  - out_valid=0, in_ready=0, busy=0, done=0, out_err=0;
  - out_instr=0, out_addr=0, addr=0, remaining=0, err_count=0.
REQ-029 rst mid-burst discards any held word without a handshake; after release, the block waits in IDLE for a new start.

Verification
REQ-030 start, base=0x100, len=3, out_ready=1; inputs in order:
  - addi x1,x0,5 → 0x00500093 @0x100;
  - add x3,x1,x2 → 0x002081B3 @0x104;
  - sw x2,8(x1) → 0x0020A423 @0x108;
  - then done 1-cycle pulse, busy falls.
REQ-031 beq x1,x2,-4 → 0xFE208EE3; jal x0,0 → 0x0000006F; lui x5,0x12345 → 0x123452B7; all with out_err=0.
REQ-032 Illegal inputs, each → out_instr 0x00000013, out_err=1; err_count ends at 3:
  - I-ALU with imm=4096;
  - BRANCH with imm=3;
  - type=12.
REQ-033 Backpressure: out_ready held 0 for 5 cycles with in_valid=1:
  - exactly one word is held stable;
  - in_ready=0 throughout;
  - no word is lost or duplicated after release.
REQ-034 Boundary cases:
  - len=0 → done 3 cycles after start, no out_valid;
  - base=0xFFFFFFFC, len=2 → addresses 0xFFFFFFFC then 0x00000000.
REQ-035 rst asserted asynchronously mid-burst with a word held → out_valid=0 within the same cycle; a later start with len=1 encodes correctly at the new base.
